// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared FSM state, FIFO entry type and data-bits encoding for the UART receiver.
package uart_rx_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

    typedef struct packed {
        logic [7:0] data;
        logic       parity_err;
        logic       frame_err;
    } rx_entry_t;

    localparam logic [1:0] DBITS_5 = 2'b00;
    localparam logic [1:0] DBITS_6 = 2'b01;
    localparam logic [1:0] DBITS_7 = 2'b10;
    localparam logic [1:0] DBITS_8 = 2'b11;

    function automatic logic [3:0] num_bits(input logic [1:0] cfg);
        return {2'b00, cfg} + 4'd5;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial pin, frame config and receive-FIFO drain signals of the UART receiver.
// break_det exists only when UART_RX_BREAK_DET_EN is defined.
interface uart_rx_if #(
    parameter int FIFO_DEPTH = 8
);
    logic                          baud_tick;
    logic                          rx;
    logic [1:0]                    cfg_data_bits;
    logic                          cfg_parity_en;
    logic                          cfg_parity_odd;
    logic                          cfg_stop2;
    logic [7:0]                    rx_data;
    logic                          rx_valid;
    logic                          rx_ready;
    logic                          rx_parity_err;
    logic                          rx_frame_err;
    logic                          rx_done;
    logic                          overrun_err;
    logic                          overrun_clr;
    logic                          rts_n;
    logic [$clog2(FIFO_DEPTH):0]   fifo_level;
`ifdef UART_RX_BREAK_DET_EN
    logic                          break_det;
`endif

    modport slave (
        input  baud_tick, rx, cfg_data_bits, cfg_parity_en, cfg_parity_odd, cfg_stop2,
        input  rx_ready, overrun_clr,
`ifdef UART_RX_BREAK_DET_EN
        output break_det,
`endif
        output rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_done, overrun_err, rts_n, fifo_level
    );

    modport master (
        output baud_tick, rx, cfg_data_bits, cfg_parity_en, cfg_parity_odd, cfg_stop2,
        output rx_ready, overrun_clr,
`ifdef UART_RX_BREAK_DET_EN
        input  break_det,
`endif
        input  rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_done, overrun_err, rts_n, fifo_level
    );

endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous FIFO of DEPTH entries of type T; a pop frees space for a same-cycle push when full.
module uart_rx_fifo #(
    parameter int  DEPTH = 8,
    parameter type T     = logic
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  T                         wdata,
    output T                         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    T               mem_q [DEPTH];
    logic [AW-1:0]  wr_q, rd_q;
    logic [AW:0]    level_q;
    logic           do_push, do_pop;

    assign empty   = level_q == '0;
    assign full    = level_q == (AW+1)'(DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign level   = level_q;
    assign rdata   = mem_q[rd_q];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            wr_q    <= wr_q + AW'(do_push);
            rd_q    <= rd_q + AW'(do_pop);
            level_q <= level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata;
    end

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampled UART receiver with runtime frame format, receive FIFO and RTS_n flow control.
// Define UART_RX_BREAK_DET_EN to add sticky break detection (break frames are then not queued).
module uart_rx_core
    import uart_rx_pkg::*;
#(
    parameter int OVS        = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int RTS_THRESH = 6
) (
    input logic      clk,
    input logic      reset_n,
    uart_rx_if.slave bus
);
    localparam int             CW   = $clog2(OVS);
    localparam int             LW   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]  HALF = CW'(OVS / 2 - 1);
    localparam logic [CW-1:0]  FULL = CW'(OVS - 1);

    state_e          state_q, state_d;
    logic            rx_s1_q, rx_s2_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      data_q, data_d;
    logic [3:0]      nbits_q, nbits_d;
    logic            par_en_q, par_en_d, par_odd_q, par_odd_d, stop2_q, stop2_d;
    logic            stop_idx_q, stop_idx_d, par_err_q, par_err_d, frame_err_q, frame_err_d;
    logic            push_q, push_d, overrun_q, overrun_d, rts_q;
    rx_entry_t       entry_q, entry_d, head;
    logic [LW-1:0]   level;
    logic            hit, fifo_full, fifo_empty, brk, brk_wait;

`ifdef UART_RX_BREAK_DET_EN
    logic brk_wait_q, brk_wait_d, break_q, break_d;
    assign brk_wait = brk_wait_q;
    // With all-zero data, the received parity bit was 0 exactly when par_err equals the odd setting.
    assign brk = state_q == STOP && hit && !stop_idx_q && data_q == '0 && !rx_s2_q &&
                 (!par_en_q || par_err_q == par_odd_q);
`else
    assign brk_wait = 1'b0;
    assign brk      = 1'b0;
`endif

    assign hit = bus.baud_tick && cnt_q == (state_q == START ? HALF : FULL);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            cnt_q       <= '0;
            bit_q       <= '0;
            data_q      <= '0;
            nbits_q     <= '0;
            par_en_q    <= 1'b0;
            par_odd_q   <= 1'b0;
            stop2_q     <= 1'b0;
            stop_idx_q  <= 1'b0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            push_q      <= 1'b0;
            entry_q     <= '0;
            overrun_q   <= 1'b0;
            rts_q       <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            brk_wait_q  <= 1'b0;
            break_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rx_s1_q     <= bus.rx;
            rx_s2_q     <= rx_s1_q;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            data_q      <= data_d;
            nbits_q     <= nbits_d;
            par_en_q    <= par_en_d;
            par_odd_q   <= par_odd_d;
            stop2_q     <= stop2_d;
            stop_idx_q  <= stop_idx_d;
            par_err_q   <= par_err_d;
            frame_err_q <= frame_err_d;
            push_q      <= push_d;
            entry_q     <= entry_d;
            overrun_q   <= overrun_d;
            rts_q       <= level >= LW'(RTS_THRESH);
`ifdef UART_RX_BREAK_DET_EN
            brk_wait_q  <= brk_wait_d;
            break_q     <= break_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = bus.baud_tick ? (hit ? '0 : cnt_q + CW'(1)) : cnt_q;
        bit_d       = bit_q;
        data_d      = data_q;
        nbits_d     = nbits_q;
        par_en_d    = par_en_q;
        par_odd_d   = par_odd_q;
        stop2_d     = stop2_q;
        stop_idx_d  = stop_idx_q;
        par_err_d   = par_err_q;
        frame_err_d = frame_err_q;
        push_d      = 1'b0;
        entry_d     = entry_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s2_q && !brk_wait) state_d = START;
            end
            START: if (hit) begin
                state_d    = rx_s2_q ? IDLE : DATA;
                bit_d      = '0;
                data_d     = '0;
                nbits_d    = num_bits(bus.cfg_data_bits);
                par_en_d   = bus.cfg_parity_en;
                par_odd_d  = bus.cfg_parity_odd;
                stop2_d    = bus.cfg_stop2;
                stop_idx_d = 1'b0;
                par_err_d  = 1'b0;
            end
            DATA: if (hit) begin
                data_d[bit_q] = rx_s2_q;
                bit_d         = bit_q + 3'd1;
                if ({1'b0, bit_q} == nbits_q - 4'd1) state_d = par_en_q ? PARITY : STOP;
            end
            PARITY: if (hit) begin
                par_err_d = ((^data_q) ^ rx_s2_q) != par_odd_q;
                state_d   = STOP;
            end
            STOP: if (hit) begin
                frame_err_d = (stop_idx_q && frame_err_q) || !rx_s2_q;
                stop_idx_d  = 1'b1;
                if (brk) state_d = IDLE;
                else if (!(stop2_q && !stop_idx_q)) begin
                    state_d = IDLE;
                    push_d  = 1'b1;
                    entry_d = {data_q, par_err_q, frame_err_d};
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef UART_RX_BREAK_DET_EN
        brk_wait_d = brk || (brk_wait_q && !rx_s2_q);
        break_d    = brk || (break_q && !bus.overrun_clr);
`endif
    end

    always_comb begin
        overrun_d         = (push_q && fifo_full && !bus.rx_ready) || (overrun_q && !bus.overrun_clr);
        bus.rx_data       = fifo_empty ? '0 : head.data;
        bus.rx_parity_err = !fifo_empty && head.parity_err;
        bus.rx_frame_err  = !fifo_empty && head.frame_err;
        bus.rx_valid      = !fifo_empty;
        bus.rx_done       = push_q;
        bus.overrun_err   = overrun_q;
        bus.rts_n         = rts_q;
        bus.fifo_level    = level;
`ifdef UART_RX_BREAK_DET_EN
        bus.break_det     = break_q;
`endif
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (rx_entry_t)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_q),
        .pop     (bus.rx_ready),
        .wdata   (entry_q),
        .rdata   (head),
        .level   (level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed frames into uart_rx_core (OVS=16, baud_tick every 2nd clk) with hand-computed results.
// Covers the UART_RX_BREAK_DET_EN build as well as the default one.
module tb_uart_rx_core;
    import uart_rx_pkg::*;

    localparam int BITC = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   vecs = 0;
    int   errs = 0;
    int   done_cnt = 0;
    int   d0;

    uart_rx_if #(.FIFO_DEPTH(8)) u_if ();

    uart_rx_core #(
        .OVS        (16),
        .FIFO_DEPTH (8),
        .RTS_THRESH (6)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (u_if)
    );

    always #5 clk = ~clk;

    initial begin
        u_if.baud_tick = 1'b0;
        forever begin
            @(negedge clk);
            u_if.baud_tick = ~u_if.baud_tick;
        end
    end

    always @(negedge clk) if (u_if.rx_done === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input int n = BITC);
        u_if.rx = b;
        clks(n);
    endtask

    task automatic set_cfg(input logic [1:0] db, input logic pen, input logic podd, input logic s2);
        u_if.cfg_data_bits  = db;
        u_if.cfg_parity_en  = pen;
        u_if.cfg_parity_odd = podd;
        u_if.cfg_stop2      = s2;
    endtask

    // A bad stop bit is held low only 3/4 of a bit so the trailing edge cannot be mistaken for a start.
    task automatic send_frame(input logic [7:0] d, input int nb, input logic pen, input logic podd,
                              input logic s2, input logic flip, input logic bad_stop);
        logic [7:0] m;
        m = d & 8'((1 << nb) - 1);
        send_bit(1'b0);
        for (int i = 0; i < nb; i++) send_bit(m[i]);
        if (pen) send_bit((^m) ^ podd ^ flip);
        if (bad_stop) begin
            send_bit(1'b0, 24);
            send_bit(1'b1, 40);
        end else repeat (s2 ? 2 : 1) send_bit(1'b1);
        clks(8);
    endtask

    task automatic pop();
        u_if.rx_ready = 1'b1;
        clks(1);
        u_if.rx_ready = 1'b0;
        clks(1);
    endtask

    initial begin
        u_if.rx          = 1'b1;
        u_if.rx_ready    = 1'b0;
        u_if.overrun_clr = 1'b0;
        set_cfg(DBITS_8, 1'b0, 1'b0, 1'b0);
        clks(3);
        chk("rst_valid", u_if.rx_valid, 0);
        chk("rst_data", u_if.rx_data, 0);
        chk("rst_perr", u_if.rx_parity_err, 0);
        chk("rst_ferr", u_if.rx_frame_err, 0);
        chk("rst_done", u_if.rx_done, 0);
        chk("rst_ovr", u_if.overrun_err, 0);
        chk("rst_rts", u_if.rts_n, 0);
        chk("rst_level", u_if.fifo_level, 0);
        reset_n = 1'b1;
        clks(4);

        d0 = done_cnt;
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("8n1_valid", u_if.rx_valid, 1);
        chk("8n1_data", u_if.rx_data, 8'hA5);
        chk("8n1_perr", u_if.rx_parity_err, 0);
        chk("8n1_ferr", u_if.rx_frame_err, 0);
        chk("8n1_done_pulses", done_cnt - d0, 1);
        chk("8n1_level", u_if.fifo_level, 1);
        pop();
        chk("8n1_level_pop", u_if.fifo_level, 0);
        chk("8n1_valid_pop", u_if.rx_valid, 0);

        set_cfg(DBITS_7, 1'b1, 1'b0, 1'b1);
        send_frame(8'h35, 7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(8'h35, 7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("7e2_level", u_if.fifo_level, 2);
        chk("7e2_e0_data", u_if.rx_data, 8'h35);
        chk("7e2_e0_perr", u_if.rx_parity_err, 0);
        chk("7e2_e0_ferr", u_if.rx_frame_err, 0);
        pop();
        chk("7e2_e1_data", u_if.rx_data, 8'h35);
        chk("7e2_e1_perr", u_if.rx_parity_err, 1);
        chk("7e2_e1_ferr", u_if.rx_frame_err, 0);
        pop();

        set_cfg(DBITS_5, 1'b1, 1'b1, 1'b0);
        send_frame(8'hF3, 5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("5o1_data", u_if.rx_data, 8'h13);
        chk("5o1_perr", u_if.rx_parity_err, 0);
        chk("5o1_ferr", u_if.rx_frame_err, 0);
        pop();

        set_cfg(DBITS_8, 1'b0, 1'b0, 1'b0);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("fe_level", u_if.fifo_level, 1);
        chk("fe_data", u_if.rx_data, 8'h3C);
        chk("fe_ferr", u_if.rx_frame_err, 1);
        chk("fe_perr", u_if.rx_parity_err, 0);
        pop();
        d0 = done_cnt;
        send_bit(1'b0, 8);
        send_bit(1'b1, 64);
        chk("glitch_level", u_if.fifo_level, 0);
        chk("glitch_done", done_cnt - d0, 0);
        chk("glitch_idle", dut.state_q, IDLE);

        d0 = done_cnt;
        for (int i = 1; i <= 9; i++) begin
            send_frame(8'(i), 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (i == 5) chk("rts_lvl5", u_if.rts_n, 0);
            if (i == 6) chk("rts_lvl6", u_if.rts_n, 1);
            if (i == 8) chk("ovr_before", u_if.overrun_err, 0);
        end
        chk("ovr_set", u_if.overrun_err, 1);
        chk("ovr_level", u_if.fifo_level, 8);
        chk("ovr_done_pulses", done_cnt - d0, 9);
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("drain_data%0d", i), u_if.rx_data, i);
            pop();
            chk($sformatf("drain_rts%0d", i), u_if.rts_n, (8 - i) >= 6);
        end
        chk("drain_valid", u_if.rx_valid, 0);
        u_if.overrun_clr = 1'b1;
        clks(1);
        u_if.overrun_clr = 1'b0;
        clks(1);
        chk("ovr_clr", u_if.overrun_err, 0);

        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_level", u_if.fifo_level, 1);
        send_bit(1'b0);
        send_bit(1'b1, 3 * BITC + 10);
        reset_n = 1'b0;
        clks(2);
        chk("mid_rst_valid", u_if.rx_valid, 0);
        chk("mid_rst_data", u_if.rx_data, 0);
        chk("mid_rst_level", u_if.fifo_level, 0);
        chk("mid_rst_rts", u_if.rts_n, 0);
        chk("mid_rst_done", u_if.rx_done, 0);
        reset_n = 1'b1;
        clks(2 * BITC);
        chk("post_rst_level", u_if.fifo_level, 0);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_data", u_if.rx_data, 8'h5A);
        chk("post_rst_ferr", u_if.rx_frame_err, 0);
        chk("post_rst_level", u_if.fifo_level, 1);
        pop();

        d0 = done_cnt;
`ifdef UART_RX_BREAK_DET_EN
        send_bit(1'b0, 20 * BITC);
        send_bit(1'b1, 2 * BITC);
        chk("brk_det", u_if.break_det, 1);
        chk("brk_level", u_if.fifo_level, 0);
        chk("brk_done", done_cnt - d0, 0);
        u_if.overrun_clr = 1'b1;
        clks(1);
        u_if.overrun_clr = 1'b0;
        clks(1);
        chk("brk_clr", u_if.break_det, 0);
        send_frame(8'h66, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("brk_after_data", u_if.rx_data, 8'h66);
        pop();
`else
        send_bit(1'b0, 9 * BITC + 24);
        send_bit(1'b1, 48);
        chk("brk_level", u_if.fifo_level, 1);
        chk("brk_data", u_if.rx_data, 0);
        chk("brk_ferr", u_if.rx_frame_err, 1);
        chk("brk_done", done_cnt - d0, 1);
        pop();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
